// File: rtl/proc_pkg.sv
// Shared types for the run controller.
//   run_state_t : controller state encoding
//   mem_sel_t   : which requester owns the data-memory write port
//   DW          : byte-wide data/address width of the memory ports
package proc_pkg;

  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } run_state_t;

  typedef enum logic [1:0] {
    SelNone,
    SelHost,
    SelCore
  } mem_sel_t;

  // Port ownership is purely a function of the controller state.
  function automatic mem_sel_t sel_for_state(run_state_t st);
    mem_sel_t sel;
    case (st)
      StLoad:  sel = SelHost;
      StRun:   sel = SelCore;
      default: sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mem_port_mux.sv
// Data-memory write-port multiplexer.
//   sel_i                                    : owner select from the controller FSM
//   host_valid_i, host_addr_i, host_wdat_i   : host memory-load port
//   core_we_i, core_addr_i, core_wdat_i      : core store port
//   mem_we_o, mem_addr_o, mem_wdat_o         : data-memory write port
// The non-owning requester is fully ignored; with no owner the port is idle
// and address/data sit at zero.
module mem_port_mux
  import proc_pkg::*;
(
  input  mem_sel_t        sel_i,
  input  logic            host_valid_i,
  input  logic [DW-1:0]   host_addr_i,
  input  logic [DW-1:0]   host_wdat_i,
  input  logic            core_we_i,
  input  logic [DW-1:0]   core_addr_i,
  input  logic [DW-1:0]   core_wdat_i,
  output logic            mem_we_o,
  output logic [DW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdat_o
);

  always_comb begin
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_wdat_o = '0;
    case (sel_i)
      SelHost: begin
        mem_we_o   = host_valid_i;
        mem_addr_o = host_addr_i;
        mem_wdat_o = host_wdat_i;
      end
      SelCore: begin
        mem_we_o   = core_we_i;
        mem_addr_o = core_addr_i;
        mem_wdat_o = core_wdat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: loads program memory from the host, runs the core until it
// halts or a cycle limit expires, then reports completion.
//   clk, reset (sync, active-low)   : clock and reset
//   req / done                      : host run handshake (level)
//   host_valid/last/addr/wdat/ready : host memory-load port
//   core_we/addr/wdat, core_halt    : core store port and end-of-program flag
//   mem_we/addr/wdat                : data-memory write port
//   core_rst, core_en               : PC hold and PC advance enable
//   cyc_cnt, timeout                : RUN cycle count and limit-expiry flag
module run_ctrl
  import proc_pkg::*;
#(
  parameter int unsigned D   = 12,
  parameter int unsigned TMO = 4000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic            done,
  input  logic            host_valid,
  input  logic            host_last,
  input  logic [DW-1:0]   host_addr,
  input  logic [DW-1:0]   host_wdat,
  output logic            host_ready,
  input  logic            core_we,
  input  logic [DW-1:0]   core_addr,
  input  logic [DW-1:0]   core_wdat,
  input  logic            core_halt,
  output logic            mem_we,
  output logic [DW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdat,
  output logic            core_rst,
  output logic            core_en,
  output logic [D-1:0]    cyc_cnt,
  output logic            timeout
);

  localparam logic [D-1:0] Limit = D'(TMO - 1);

  run_state_t   state_q, state_d;
  logic [D-1:0] cnt_q, cnt_d;
  logic         tmo_q, tmo_d;
  mem_sel_t     sel_q;
  logic         core_rst_q, core_en_q, host_ready_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLoad;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      StLoad: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else if (host_valid && host_last) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end else begin
          // Count the cycle just spent in RUN; cnt_q never exceeds TMO-1 here,
          // so the result is bounded by TMO and cannot wrap.
          cnt_d = cnt_q + D'(1);
          if (core_halt) begin
            state_d = StDrain;
          end else if (cnt_q == Limit) begin
            state_d = StDrain;
            tmo_d   = 1'b1;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (!req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      tmo_q        <= 1'b0;
      sel_q        <= SelNone;
      core_rst_q   <= 1'b1;
      core_en_q    <= 1'b0;
      host_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      sel_q        <= sel_for_state(state_d);
      core_rst_q   <= (state_d == StIdle) || (state_d == StLoad);
      core_en_q    <= (state_d == StRun);
      host_ready_q <= (state_d == StLoad);
      done_q       <= (state_d == StDone);
    end
  end

  mem_port_mux u_mem_port_mux (
    .sel_i        (sel_q),
    .host_valid_i (host_valid),
    .host_addr_i  (host_addr),
    .host_wdat_i  (host_wdat),
    .core_we_i    (core_we),
    .core_addr_i  (core_addr),
    .core_wdat_i  (core_wdat),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdat_o   (mem_wdat)
  );

  assign done       = done_q;
  assign host_ready = host_ready_q;
  assign core_rst   = core_rst_q;
  assign core_en    = core_en_q;
  assign cyc_cnt    = cnt_q;
  assign timeout    = tmo_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl: normal run, timeout, halt/limit coincidence,
// abort, port isolation and reset during LOAD.
module tb_run_ctrl;

  localparam int unsigned D   = 12;
  localparam int unsigned TMO = 20;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic         done;
  logic         host_valid, host_last;
  logic [7:0]   host_addr, host_wdat;
  logic         host_ready;
  logic         core_we;
  logic [7:0]   core_addr, core_wdat;
  logic         core_halt;
  logic         mem_we;
  logic [7:0]   mem_addr, mem_wdat;
  logic         core_rst, core_en;
  logic [D-1:0] cyc_cnt;
  logic         timeout;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;
  logic [7:0] tb_mem [256];

  always #5 clk = ~clk;

  run_ctrl #(.D(D), .TMO(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .host_valid (host_valid),
    .host_last  (host_last),
    .host_addr  (host_addr),
    .host_wdat  (host_wdat),
    .host_ready (host_ready),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdat  (core_wdat),
    .core_halt  (core_halt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdat   (mem_wdat),
    .core_rst   (core_rst),
    .core_en    (core_en),
    .cyc_cnt    (cyc_cnt),
    .timeout    (timeout)
  );

  // Data memory model fed by the write port.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      tb_mem[mem_addr] <= mem_wdat;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_done"},       32'(done),       32'd0);
    chk({pfx, "_host_ready"}, 32'(host_ready), 32'd0);
    chk({pfx, "_mem_we"},     32'(mem_we),     32'd0);
    chk({pfx, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({pfx, "_mem_wdat"},   32'(mem_wdat),   32'd0);
    chk({pfx, "_core_rst"},   32'(core_rst),   32'd1);
    chk({pfx, "_core_en"},    32'(core_en),    32'd0);
    chk({pfx, "_cyc_cnt"},    32'(cyc_cnt),    32'd0);
    chk({pfx, "_timeout"},    32'(timeout),    32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
    reset = 1'b0; req = 1'b0;
    host_valid = 1'b0; host_last = 1'b0; host_addr = '0; host_wdat = '0;
    core_we = 1'b0; core_addr = '0; core_wdat = '0; core_halt = 1'b0;
    repeat (2) tick();
    chk_reset_values("por");
    reset = 1'b1;

    // Normal run with port isolation.
    req = 1'b1;
    tick();                                   // LOAD
    chk("load_ready", 32'(host_ready), 32'd1);
    chk("load_cnt",   32'(cyc_cnt),    32'd0);
    chk("load_rst",   32'(core_rst),   32'd1);
    core_we = 1'b1; core_addr = 8'h55; core_wdat = 8'hEE;
    host_valid = 1'b1; host_addr = 8'h10; host_wdat = 8'hA1;
    #1;
    chk("load_we",   32'(mem_we),   32'd1);
    chk("load_addr", 32'(mem_addr), 32'h10);
    chk("load_wdat", 32'(mem_wdat), 32'hA1);
    tick();
    host_addr = 8'h11; host_wdat = 8'hB2;
    tick();
    host_addr = 8'h12; host_wdat = 8'hC3; host_last = 1'b1;
    tick();                                   // RUN cycle 1
    host_last = 1'b0; host_addr = 8'h77; host_wdat = 8'h99; core_we = 1'b0;
    #1;
    chk("run_iso_we", 32'(mem_we),     32'd0);
    chk("run_en",     32'(core_en),    32'd1);
    chk("run_rst",    32'(core_rst),   32'd0);
    chk("run_ready",  32'(host_ready), 32'd0);
    chk("run1_cnt",   32'(cyc_cnt),    32'd0);
    tick();                                   // RUN cycle 2
    host_valid = 1'b0; core_we = 1'b1; core_addr = 8'h20; core_wdat = 8'h5A;
    #1;
    chk("run_core_we",   32'(mem_we),   32'd1);
    chk("run_core_wdat", 32'(mem_wdat), 32'h5A);
    tick();                                   // RUN cycle 3
    core_we = 1'b0;
    repeat (7) tick();                        // RUN cycle 10
    chk("run10_cnt", 32'(cyc_cnt), 32'd9);
    core_halt = 1'b1;
    tick();                                   // DRAIN
    core_halt = 1'b0; core_we = 1'b1; core_addr = 8'h66;
    #1;
    chk("drain_we",   32'(mem_we),  32'd0);
    chk("drain_en",   32'(core_en), 32'd0);
    chk("drain_done", 32'(done),    32'd0);
    chk("drain_cnt",  32'(cyc_cnt), 32'd10);
    tick();                                   // DONE
    core_we = 1'b0;
    chk("norm_done",    32'(done),    32'd1);
    chk("norm_cnt",     32'(cyc_cnt), 32'd10);
    chk("norm_timeout", 32'(timeout), 32'd0);
    chk("mem_10", 32'(tb_mem[8'h10]), 32'hA1);
    chk("mem_11", 32'(tb_mem[8'h11]), 32'hB2);
    chk("mem_12", 32'(tb_mem[8'h12]), 32'hC3);
    chk("mem_20", 32'(tb_mem[8'h20]), 32'h5A);
    chk("mem_55_stray", 32'(tb_mem[8'h55]), 32'h00);
    chk("mem_77_stray", 32'(tb_mem[8'h77]), 32'h00);
    chk("mem_66_stray", 32'(tb_mem[8'h66]), 32'h00);
    chk("write_count",  32'(wr_cnt), 32'd4);
    req = 1'b0;
    tick();                                   // IDLE
    chk("idle_done", 32'(done),     32'd0);
    chk("idle_rst",  32'(core_rst), 32'd1);

    // Timeout: halt never asserted.
    req = 1'b1;
    tick();
    host_valid = 1'b1; host_last = 1'b1; host_addr = 8'h30; host_wdat = 8'h33;
    tick();                                   // RUN cycle 1
    host_valid = 1'b0; host_last = 1'b0;
    repeat (19) tick();                       // RUN cycle 20
    chk("tmo_run20_cnt", 32'(cyc_cnt), 32'd19);
    chk("tmo_run20_en",  32'(core_en), 32'd1);
    chk("tmo_run20_flag", 32'(timeout), 32'd0);
    tick();                                   // DRAIN
    chk("tmo_drain_cnt",  32'(cyc_cnt), 32'd20);
    chk("tmo_drain_flag", 32'(timeout), 32'd1);
    chk("tmo_drain_en",   32'(core_en), 32'd0);
    tick();                                   // DONE
    chk("tmo_done",      32'(done),    32'd1);
    chk("tmo_done_cnt",  32'(cyc_cnt), 32'd20);
    chk("tmo_done_flag", 32'(timeout), 32'd1);
    tick();
    chk("tmo_hold_cnt",  32'(cyc_cnt), 32'd20);
    chk("tmo_hold_done", 32'(done),    32'd1);
    req = 1'b0;
    tick();

    // Halt coincides with the limit.
    req = 1'b1;
    tick();
    chk("co_load_flag", 32'(timeout), 32'd0);
    chk("co_load_cnt",  32'(cyc_cnt), 32'd0);
    host_valid = 1'b1; host_last = 1'b1;
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    repeat (19) tick();
    chk("co_run20_cnt", 32'(cyc_cnt), 32'd19);
    core_halt = 1'b1;
    tick();                                   // DRAIN
    core_halt = 1'b0;
    chk("co_drain_flag", 32'(timeout), 32'd0);
    chk("co_drain_cnt",  32'(cyc_cnt), 32'd20);
    tick();                                   // DONE
    chk("co_done",      32'(done),    32'd1);
    chk("co_done_flag", 32'(timeout), 32'd0);
    req = 1'b0;
    tick();

    // Abort during RUN.
    req = 1'b1;
    tick();
    host_valid = 1'b1; host_last = 1'b1;
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    repeat (4) tick();                        // RUN cycle 5
    chk("ab_run5_cnt", 32'(cyc_cnt), 32'd4);
    req = 1'b0;
    tick();
    chk("ab_rst",   32'(core_rst),   32'd1);
    chk("ab_done",  32'(done),       32'd0);
    chk("ab_cnt",   32'(cyc_cnt),    32'd0);
    chk("ab_en",    32'(core_en),    32'd0);
    chk("ab_ready", 32'(host_ready), 32'd0);

    // Reset in the middle of LOAD.
    req = 1'b1;
    tick();
    host_valid = 1'b1; host_addr = 8'h40; host_wdat = 8'h44;
    tick();
    host_addr = 8'h41; host_wdat = 8'h45;
    tick();
    reset = 1'b0;
    tick();
    chk_reset_values("mid_load_rst");
    reset = 1'b1; host_valid = 1'b0;
    tick();                                   // LOAD again
    chk("rl_ready", 32'(host_ready), 32'd1);
    chk("rl_cnt",   32'(cyc_cnt),    32'd0);
    chk("rl_mem41", 32'(tb_mem[8'h41]), 32'h45);
    host_valid = 1'b1; host_last = 1'b1;
    tick();
    host_valid = 1'b0; host_last = 1'b0;
    chk("rl_run_en", 32'(core_en), 32'd1);
    req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
